tt_io_sequencer: RTL
====================

// Module: tt_io_sequencer
// PURPOSE
//   Host-side driver for the TinyTapeout user-project pin interface: the opposite end of the
//   ui_in/uio_in -> uo_out/uio_out/uio_oe boundary that the cocotb bench drives today.
//   Consumes a byte-wide command stream (valid/ready), drives ui_in/uio_in of a tt_um_* DUT,
//   waits programmable cycle counts, and returns sampled DUT outputs as a byte response stream.
//   Lets on-board/FPGA harnesses replay bench-style sequences without a simulator.
// PARAMETERS
//   SYNC_STAGES  2   flops on uo_out/uio_out/uio_oe before sampling (0 = sample raw)
//   WAIT_W       8   width of WAIT argument / down-counter
// PORTS
//   clk          in   1  single clock, all logic rising-edge
//   rst          in   1  synchronous, active-high reset
//   cmd_valid    in   1  command byte valid
//   cmd_ready    out  1  sequencer accepts cmd_data this cycle
//   cmd_data     in   8  opcode or argument byte
//   rsp_valid    out  1  response byte valid
//   rsp_ready    in   1  downstream accepts rsp_data
//   rsp_data     out  8  response byte
//   ui_drv       out  8  to DUT ui_in
//   uio_drv      out  8  to DUT uio_in
//   dut_uo       in   8  from DUT uo_out
//   dut_uio_out  in   8  from DUT uio_out
//   dut_uio_oe   in   8  from DUT uio_oe
//   busy         out  1  high in any state other than IDLE
//   err          out  1  sticky: unknown opcode seen; cleared only by rst
// BEHAVIOUR
//   Reset (rst=1 at clk edge): state=IDLE, ui_drv=0, uio_drv=0, rsp_valid=0, rsp_data=0,
//     err=0, busy=0, wait counter=0, sync flops=0. Reset mid-command abandons it; no response.
//   Opcodes: 0x01 SET_UI <b>; 0x02 SET_UIO <b>; 0x03 WAIT <n>; 0x04 SAMPLE; others = unknown.
//   cmd_ready=1 only in IDLE and ARG; a byte transfers when cmd_valid&cmd_ready at clk edge.
//   IDLE: 0x01/0x02/0x03 -> ARG (opcode latched); 0x04 -> RSP0 with snapshot of synced
//     {uo,uio_out,uio_oe} taken that same edge; unknown -> err<=1, stay IDLE.
//   ARG: SET_UI -> ui_drv<=b, IDLE; SET_UIO -> uio_drv<=b, IDLE (no oe masking: DUT owns
//     contention); WAIT -> cnt<=n; n==0 -> IDLE, else -> WAIT.
//   WAIT: cnt decrements each cycle; leaves to IDLE on the edge where cnt==1 (exactly n
//     cycles in WAIT, cmd_ready=0 throughout). cmd_valid ignored, not lost.
//   SET_* takes effect on the edge the argument is accepted; new value visible next cycle.
//   RSP0/1/2: rsp_valid=1, rsp_data = uo, uio_out, uio_oe snapshot respectively; advance on
//     rsp_valid&rsp_ready; RSP2 handshake -> IDLE. rsp_data stable while rsp_valid&!rsp_ready.
//   Snapshot path: SYNC_STAGES cycles of pipeline; SAMPLE reflects DUT outputs SYNC_STAGES
//     cycles before the opcode edge. Snapshot frozen until RSP2 completes.
//   Throughput: SET_* = 2 cycles min; SAMPLE = 1 + 3 response cycles min (rsp_ready=1).
//   ui_drv/uio_drv hold last value across WAIT, SAMPLE and err; only SET_* or rst change them.
//   cnt is WAIT_W bits, unsigned; n=255 (WAIT_W=8) gives 255 cycles, no wrap.
// TESTING
//   rst 3 cycles -> ui_drv=uio_drv=0, rsp_valid=0, err=0, cmd_ready=1.
//   Send 01 A5, 02 3C -> ui_drv=0xA5 cycle after byte 2, uio_drv=0x3C after byte 4.
//   DUT loopback uo=ui; 01 5A, 03 04, 04 with rsp_ready=1 -> cmd_ready low 4 cycles,
//     responses 5A, uio_out, uio_oe in order; busy low after third byte.
//   03 00 -> back to IDLE next cycle, cmd_ready never low in WAIT; 03 FF -> 255 cycles low.
//   SAMPLE with rsp_ready toggling 1-in-3 -> rsp_data stable under backpressure, 3 bytes exact.
//   Send 7F then 01 11 -> err=1 sticky, ui_drv=0x11; assert rst mid-WAIT -> IDLE, err=0.

Source files
------------

// File: rtl/tt_io_sequencer.sv
// ----------------------------------------------------------------------------
// tt_io_sequencer
//
// Host-side driver for a TinyTapeout user-project pin interface. It sits on the
// far side of the ui_in/uio_in -> uo_out/uio_out/uio_oe boundary. It takes a
// byte-wide command stream, drives the DUT inputs, waits for programmed cycle
// counts, and returns snapshots of the DUT outputs as a byte response stream.
// This lets an FPGA or on-board harness replay bench-style sequences.
//
// Command set (opcode byte, optional argument byte):
//   0x01 <b>  SET_UI   ui_drv  <= b
//   0x02 <b>  SET_UIO  uio_drv <= b
//   0x03 <n>  WAIT     hold off the command stream for n cycles
//   0x04      SAMPLE   respond with uo_out, uio_out, uio_oe (three bytes)
//   any other opcode sets the sticky err flag and is otherwise dropped
//
// Parameters:
//   SYNC_STAGES  flops on the DUT output bus before it is sampled (0 = raw)
//   WAIT_W       width of the WAIT down-counter
//
// Ports:
//   clk, rst                 single rising-edge clock, synchronous active-high reset
//   cmd_valid/ready/data     command byte stream into the sequencer
//   rsp_valid/ready/data     response byte stream out of the sequencer
//   ui_drv, uio_drv          driven onto DUT ui_in / uio_in
//   dut_uo, dut_uio_out,
//   dut_uio_oe               DUT outputs, synchronised before sampling
//   busy                     high whenever the sequencer is not idle
//   err                      sticky unknown-opcode flag, cleared only by rst
// ----------------------------------------------------------------------------
module tt_io_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] ui_drv,
  output logic [7:0] uio_drv,
  input  logic [7:0] dut_uo,
  input  logic [7:0] dut_uio_out,
  input  logic [7:0] dut_uio_oe,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] OP_SET_UI  = 8'h01;
  localparam logic [7:0] OP_SET_UIO = 8'h02;
  localparam logic [7:0] OP_WAIT    = 8'h03;
  localparam logic [7:0] OP_SAMPLE  = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_WAIT,
    S_RSP0,
    S_RSP1,
    S_RSP2
  } state_t;

  // Which argument-taking command is waiting for its argument byte.
  typedef enum logic [1:0] {
    K_SET_UI,
    K_SET_UIO,
    K_WAIT
  } pend_t;

  state_t              state_q, state_d;
  pend_t               pend_q, pend_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          ui_q, ui_d;
  logic [7:0]          uio_q, uio_d;
  logic [23:0]         snap_q, snap_d;
  logic                err_q, err_d;

  logic [23:0]         dut_raw;
  logic [23:0]         dut_synced;
  logic [WAIT_W-1:0]   arg_cnt;

  assign dut_raw = {dut_uo, dut_uio_out, dut_uio_oe};

  // The argument byte is resized to the counter width. With WAIT_W < 8 the
  // upper argument bits are dropped; with WAIT_W > 8 the value is zero-extended.
  assign arg_cnt = WAIT_W'(cmd_data);

  // Synchroniser on the DUT output bus. The DUT may run from another clock or
  // be a physical chip, so its outputs pass through SYNC_STAGES flops before
  // the SAMPLE snapshot reads them. With zero stages the raw bus is used.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign dut_synced = dut_raw;
    end else begin : g_sync
      logic [23:0] sync_q [SYNC_STAGES];
      logic [23:0] sync_d [SYNC_STAGES];

      // Each stage takes the stage before it; stage 0 takes the raw bus.
      always_comb begin
        sync_d[0] = dut_raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // Synchroniser registers, cleared by reset.
      always_ff @(posedge clk) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          if (rst) begin
            sync_q[i] <= '0;
          end else begin
            sync_q[i] <= sync_d[i];
          end
        end
      end

      assign dut_synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Next-state and handshake logic. Every register holds by default, and
  // the valid/ready outputs default low, so only the branches below change
  // anything.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    ui_d      = ui_q;
    uio_d     = uio_q;
    snap_d    = snap_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 8'h00;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_data)
            OP_SET_UI: begin
              pend_d  = K_SET_UI;
              state_d = S_ARG;
            end
            OP_SET_UIO: begin
              pend_d  = K_SET_UIO;
              state_d = S_ARG;
            end
            OP_WAIT: begin
              pend_d  = K_WAIT;
              state_d = S_ARG;
            end
            OP_SAMPLE: begin
              // The snapshot is taken on the opcode edge and then held
              // unchanged until the last response byte has been taken.
              snap_d  = dut_synced;
              state_d = S_RSP0;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      S_ARG: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (pend_q)
            K_SET_UI: begin
              ui_d    = cmd_data;
              state_d = S_IDLE;
            end
            K_SET_UIO: begin
              // uio_drv is not masked by uio_oe. Resolving contention on
              // shared pins is the DUT's job.
              uio_d   = cmd_data;
              state_d = S_IDLE;
            end
            default: begin
              cnt_d   = arg_cnt;
              state_d = (arg_cnt == '0) ? S_IDLE : S_WAIT;
            end
          endcase
        end
      end

      S_WAIT: begin
        // Leaving on the edge where the count is 1 gives exactly n cycles
        // here. The <= compare also pulls the FSM out if the count were
        // ever 0, so it can never wrap and stall for 2^WAIT_W cycles.
        if (cnt_q <= WAIT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end

      S_RSP0: begin
        rsp_valid = 1'b1;
        rsp_data  = snap_q[23:16];
        if (rsp_ready) begin
          state_d = S_RSP1;
        end
      end

      S_RSP1: begin
        rsp_valid = 1'b1;
        rsp_data  = snap_q[15:8];
        if (rsp_ready) begin
          state_d = S_RSP2;
        end
      end

      S_RSP2: begin
        rsp_valid = 1'b1;
        rsp_data  = snap_q[7:0];
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset drops any command in progress,
  // and no response is produced for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= K_SET_UI;
      cnt_q   <= '0;
      ui_q    <= 8'h00;
      uio_q   <= 8'h00;
      snap_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      ui_q    <= ui_d;
      uio_q   <= uio_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
    end
  end

  assign ui_drv  = ui_q;
  assign uio_drv = uio_q;
  assign err     = err_q;
  assign busy    = (state_q != S_IDLE);

endmodule
